// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_pkg
//  Description : Shared types and constants for the serial transmit path.
//                tx_state_t is the transmitter FSM state. It has a PARITY
//                member only when SERIAL_TX_PARITY_EN is defined.
//                frame_bits() returns the number of serial bits in a frame.
//  Macro       : SERIAL_TX_PARITY_EN
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_pkg;

    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef SERIAL_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } tx_state_t;

    // Number of serial bits in one frame: start + data + optional parity + stop.
    function automatic int frame_bits(input int data_w, input int stop_bits, input bit parity);
        return 1 + data_w + (parity ? 1 : 0) + stop_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_tx_if
//  Description : Groups the producer handshake signals and the serial line
//                status signals of the serial transmitter.
//                master : producer side (drives in_data, in_valid)
//                slave  : transmitter side (drives in_ready, txd, busy, tx_done)
//  Revision    : 1.0 - initial release
// ============================================================================
interface serial_tx_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              txd;
    logic              busy;
    logic              tx_done;

    modport master (
        output in_data, in_valid,
        input  in_ready, txd, busy, tx_done
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, txd, busy, tx_done
    );
endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock first-word-fall-through FIFO. Each pointer is
//                one bit wider than the address, so full and empty can be
//                told apart without a separate occupancy counter. A push
//                while full and a pop while empty are both ignored.
//  Ports       : clk, rst (async, active high)
//                push, wr_data      - write side
//                pop, rd_data       - read side (rd_data shows the head entry)
//                full, empty        - status flags
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of 2 and >= 2");
    end

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign empty     = (r_wr_ptr == r_rd_ptr);
    // Full: the addresses match but the write pointer has wrapped once more.
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign rd_data   = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/serial_tx.sv
`default_nettype none
// ============================================================================
//  Module      : serial_tx
//  Description : Asynchronous serial transmitter with a FIFO-backed
//                valid/ready input. Frame layout is start(0), DATA_W data
//                bits LSB first, an optional parity bit and STOP_BITS stop
//                bits. Each bit lasts CLKS_PER_BIT clocks. When a word is
//                queued at the end of a frame, the next frame starts with no
//                idle gap.
//  Macro       : SERIAL_TX_PARITY_EN - adds the PARITY bit and the ODD_PARITY
//                parameter
//  Ports       : clk          - system clock
//                rst          - asynchronous active-high reset
//                bus (slave)  - in_data/in_valid/in_ready handshake;
//                               txd (idle high), busy, tx_done pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
`ifdef SERIAL_TX_PARITY_EN
    ,
    parameter bit ODD_PARITY   = 1'b0
`endif
) (
    input  logic       clk,
    input  logic       rst,
    serial_tx_if.slave bus
);
    localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int              IDX_W     = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
        $error("serial_tx: DATA_W must be in 5..9");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("serial_tx: CLKS_PER_BIT must be >= 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("serial_tx: STOP_BITS must be 1 or 2");
    end

    tx_state_t         r_state, w_state_next;
    logic [CNT_W-1:0]  r_cnt, w_cnt_next;
    logic [IDX_W-1:0]  r_idx, w_idx_next;      // data bit index, reused as stop bit index
    logic [DATA_W-1:0] r_data, w_data_next;
    logic              r_txd, w_txd_next;
    logic              r_done, w_done_next;
    logic              w_pop;
    logic              w_bit_end;
    logic [DATA_W-1:0] w_fifo_dout;
    logic              w_full;
    logic              w_empty;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (bus.in_valid),
        .wr_data (bus.in_data),
        .pop     (w_pop),
        .rd_data (w_fifo_dout),
        .full    (w_full),
        .empty   (w_empty)
    );

    assign w_bit_end    = (r_cnt == CNT_LAST);
    assign bus.in_ready = !w_full;
    assign bus.txd      = r_txd;
    assign bus.tx_done  = r_done;
    assign bus.busy     = (r_state != IDLE) || !w_empty;

    // The next-state logic also computes the line level for the next cycle.
    // r_txd is therefore registered, and the level changes on the same edge
    // as the state.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + 1'b1;
        w_idx_next   = r_idx;
        w_data_next  = r_data;
        w_txd_next   = r_txd;
        w_pop        = 1'b0;

        case (r_state)
            IDLE: begin
                w_cnt_next = '0;
                w_idx_next = '0;
                w_txd_next = IDLE_LEVEL;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_data_next  = w_fifo_dout;
                    w_state_next = START;
                    w_txd_next   = 1'b0;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_state_next = DATA;
                    w_cnt_next   = '0;
                    w_idx_next   = '0;
                    w_txd_next   = r_data[0];
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    w_cnt_next = '0;
                    if (r_idx == LAST_BIT) begin
                        w_idx_next   = '0;
`ifdef SERIAL_TX_PARITY_EN
                        w_state_next = PARITY;
                        w_txd_next   = (^r_data) ^ ODD_PARITY;
`else
                        w_state_next = STOP;
                        w_txd_next   = IDLE_LEVEL;
`endif
                    end else begin
                        w_idx_next = r_idx + 1'b1;
                        w_txd_next = r_data[w_idx_next];
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                if (w_bit_end) begin
                    w_state_next = STOP;
                    w_cnt_next   = '0;
                    w_idx_next   = '0;
                    w_txd_next   = IDLE_LEVEL;
                end
            end
`endif
            STOP: begin
                if (w_bit_end) begin
                    w_cnt_next = '0;
                    if (r_idx == LAST_STOP) begin
                        w_idx_next = '0;
                        // If a word is queued, the next start bit follows the last stop bit directly.
                        if (!w_empty) begin
                            w_pop        = 1'b1;
                            w_data_next  = w_fifo_dout;
                            w_state_next = START;
                            w_txd_next   = 1'b0;
                        end else begin
                            w_state_next = IDLE;
                            w_txd_next   = IDLE_LEVEL;
                        end
                    end else begin
                        w_idx_next = r_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
                w_idx_next   = '0;
                w_txd_next   = IDLE_LEVEL;
            end
        endcase

        // tx_done is high during the last clock of the final stop bit.
        w_done_next = (w_state_next == STOP) && (w_cnt_next == CNT_LAST) &&
                      (w_idx_next == LAST_STOP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_txd   <= IDLE_LEVEL;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_data  <= w_data_next;
            r_txd   <= w_txd_next;
            r_done  <= w_done_next;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_tx
//  Description : Self-checking bench for serial_tx. A queue-based reference
//                model predicts txd, tx_done, busy and in_ready on every
//                cycle. Scenario tasks check latency, frame content, back to
//                back framing, backpressure and reset.
//                When SERIAL_TX_PARITY_EN is defined, the bench uses
//                DATA_W=7, CLKS_PER_BIT=3 and STOP_BITS=2.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_tx;
    import serial_pkg::*;

`ifdef SERIAL_TX_PARITY_EN
    localparam int DATA_W      = 7;
    localparam int CLKS        = 3;
    localparam int STOP        = 2;
    localparam bit PAR         = 1'b1;
    localparam int SINGLE_WORD = 'h07;
`else
    localparam int DATA_W      = 8;
    localparam int CLKS        = 16;
    localparam int STOP        = 1;
    localparam bit PAR         = 1'b0;
    localparam int SINGLE_WORD = 'hA5;
`endif
    localparam int DEPTH   = 4;
    localparam int FBITS   = frame_bits(DATA_W, STOP, PAR);
    localparam int FLEN    = FBITS * CLKS;
    localparam int RST_POS = (FLEN > 80) ? 40 : 2 * CLKS;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_tx_if #(.DATA_W(DATA_W)) bus ();

    serial_tx #(
        .DATA_W       (DATA_W),
        .CLKS_PER_BIT (CLKS),
        .STOP_BITS    (STOP),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int errors   = 0;
    int tot_done = 0;

    // Reference model. m_q holds the queued words and m_cur the word on the line.
    logic [DATA_W-1:0] m_q[$];
    logic [DATA_W-1:0] m_cur;
    bit                m_active = 1'b0;
    int                m_pos    = 0;
    bit                m_push;
    bit                m_pop;

    logic [31:0] e_vec;
    logic        e_txd, e_done, e_busy, e_ready;

    // Builds the frame from the word, one entry per serial bit, LSB first.
    function automatic logic [31:0] frame_vec(input logic [DATA_W-1:0] w);
        logic [31:0] v;
        v    = '1;
        v[0] = 1'b0;
        for (int i = 0; i < DATA_W; i++) v[1+i] = w[i];
`ifdef SERIAL_TX_PARITY_EN
        v[1+DATA_W] = ^w;
`endif
        return v;
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_q.delete();
                m_active = 1'b0;
                m_pos    = 0;
            end else begin
                m_push = bus.in_valid && (m_q.size() < DEPTH);
                m_pop  = (!m_active || m_pos == FLEN - 1) && (m_q.size() != 0);
                if (m_active) begin
                    if (m_pos == FLEN - 1) m_active = 1'b0;
                    else m_pos++;
                end
                if (m_pop) begin
                    m_cur    = m_q.pop_front();
                    m_active = 1'b1;
                    m_pos    = 0;
                end
                if (m_push) m_q.push_back(bus.in_data);
            end
        end
    end

    // Compares the DUT with the model on every cycle.
    initial begin
        forever begin
            @(negedge clk);
            e_vec   = frame_vec(m_cur);
            e_txd   = m_active ? e_vec[m_pos / CLKS] : 1'b1;
            e_done  = m_active && (m_pos == FLEN - 1);
            e_busy  = m_active || (m_q.size() != 0);
            e_ready = (m_q.size() < DEPTH);
            checks += 4;
            if (bus.txd !== e_txd) begin
                errors++;
                $display("FAIL line_txd t=%0t got %b want %b", $time, bus.txd, e_txd);
            end
            if (bus.tx_done !== e_done) begin
                errors++;
                $display("FAIL line_tx_done t=%0t got %b want %b", $time, bus.tx_done, e_done);
            end
            if (bus.busy !== e_busy) begin
                errors++;
                $display("FAIL line_busy t=%0t got %b want %b", $time, bus.busy, e_busy);
            end
            if (bus.in_ready !== e_ready) begin
                errors++;
                $display("FAIL line_in_ready t=%0t got %b want %b", $time, bus.in_ready, e_ready);
            end
            if (bus.tx_done === 1'b1) tot_done++;
        end
    end

    // Called at a negedge. Waits for FIFO space, then offers the word for one edge.
    task automatic push_word(input logic [DATA_W-1:0] w);
        int n;
        n = 0;
        while (m_q.size() >= DEPTH && n < 4 * FLEN) begin
            @(negedge clk);
            n++;
        end
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = DATA_W'($urandom);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < (DEPTH + 3) * FLEN) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL %s_drain busy still %b after %0d cycles", tag, bus.busy, n);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(negedge clk);
        checks += 4;
        if (bus.txd !== 1'b1) begin errors++; $display("FAIL reset_txd got %b want 1", bus.txd); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        if (bus.tx_done !== 1'b0) begin errors++; $display("FAIL reset_tx_done got %b want 0", bus.tx_done); end
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [DATA_W-1:0] w;
        logic [31:0]       rx;
        int                k;
        int                done_at;
        w       = DATA_W'(SINGLE_WORD);
        rx      = '0;
        done_at = -1;
        push_word(w);
        k = 0;
        while (bus.txd !== 1'b0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k !== 1) begin errors++; $display("FAIL single_latency got %0d want 1", k); end
        for (int c = 0; c < FLEN; c++) begin
            if (c % CLKS == CLKS / 2) rx[c / CLKS] = bus.txd;
            if (bus.tx_done === 1'b1) done_at = c + 1;
            @(negedge clk);
        end
        checks += 5;
        if (rx[0] !== 1'b0) begin errors++; $display("FAIL single_start got %b want 0", rx[0]); end
        if (rx[DATA_W:1] !== w) begin errors++; $display("FAIL single_data got %h want %h", rx[DATA_W:1], w); end
        if (rx[FBITS-1 -: STOP] !== {STOP{1'b1}}) begin
            errors++;
            $display("FAIL single_stop got %b want all ones", rx[FBITS-1 -: STOP]);
        end
        if (done_at !== FLEN) begin errors++; $display("FAIL single_done_cycle got %0d want %0d", done_at, FLEN); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_after got %b want 0", bus.busy); end
`ifdef SERIAL_TX_PARITY_EN
        checks++;
        if (rx[DATA_W+1] !== 1'b1) begin errors++; $display("FAIL single_parity got %b want 1", rx[DATA_W+1]); end
`endif
    endtask

    task automatic test_back_to_back();
        int vals[4];
        int busy_cyc;
        int dones;
        vals     = '{'h00, 'hFF, 'h55, 'h81};
        busy_cyc = 0;
        dones    = 0;
        for (int i = 0; i < 4 * FLEN + 40; i++) begin
            if (i < 4) begin
                bus.in_valid = 1'b1;
                bus.in_data  = DATA_W'(vals[i]);
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            if (bus.busy === 1'b1) busy_cyc++;
            if (bus.tx_done === 1'b1) dones++;
        end
        checks += 2;
        if (dones !== 4) begin errors++; $display("FAIL b2b_done_count got %0d want 4", dones); end
        if (busy_cyc !== 1 + 4 * FLEN) begin
            errors++;
            $display("FAIL b2b_busy_cycles got %0d want %0d", busy_cyc, 1 + 4 * FLEN);
        end
    endtask

    task automatic test_hold_valid();
        logic [DATA_W-1:0] w6[6];
        int idx;
        int low_seen;
        int done0;
        bit acc;
        for (int i = 0; i < 6; i++) w6[i] = DATA_W'($urandom);
        done0        = tot_done;
        idx          = 0;
        low_seen     = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = w6[0];
        for (int c = 0; c < 8 * FLEN && idx < 6; c++) begin
            acc = (m_q.size() < DEPTH);
            if (bus.in_ready === 1'b0) low_seen++;
            @(negedge clk);
            if (acc) begin
                idx++;
                if (idx < 6) bus.in_data = w6[idx];
            end
        end
        bus.in_valid = 1'b0;
        wait_idle("hold");
        checks += 3;
        if (idx !== 6) begin errors++; $display("FAIL hold_accepted got %0d want 6", idx); end
        if (low_seen == 0) begin errors++; $display("FAIL hold_ready_low got %0d want >0", low_seen); end
        if (tot_done - done0 !== 6) begin errors++; $display("FAIL hold_done_count got %0d want 6", tot_done - done0); end
    endtask

    task automatic test_reset_mid();
        int n;
        int lows;
        int busy_seen;
        int done0;
        push_word('0);
        push_word(DATA_W'($urandom));
        push_word(DATA_W'($urandom));
        n = 0;
        while (!(m_active && m_pos == RST_POS) && n < 4 * FLEN) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.txd !== 1'b0) begin errors++; $display("FAIL rstmid_pre_txd got %b want 0", bus.txd); end
        #2 rst = 1'b1;
        #1;
        checks += 4;
        if (bus.txd !== 1'b1) begin errors++; $display("FAIL rstmid_txd got %b want 1", bus.txd); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
        if (bus.tx_done !== 1'b0) begin errors++; $display("FAIL rstmid_tx_done got %b want 0", bus.tx_done); end
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %b want 1", bus.in_ready); end
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        lows      = 0;
        busy_seen = 0;
        for (int c = 0; c < 2 * FLEN; c++) begin
            @(negedge clk);
            if (bus.txd !== 1'b1) lows++;
            if (bus.busy !== 1'b0) busy_seen++;
        end
        checks += 2;
        if (lows !== 0) begin errors++; $display("FAIL rstmid_residual_txd got %0d low cycles want 0", lows); end
        if (busy_seen !== 0) begin errors++; $display("FAIL rstmid_residual_busy got %0d busy cycles want 0", busy_seen); end
        done0 = tot_done;
        push_word(DATA_W'($urandom));
        wait_idle("rstmid");
        checks++;
        if (tot_done - done0 !== 1) begin errors++; $display("FAIL rstmid_after_done got %0d want 1", tot_done - done0); end
    endtask

    task automatic test_push_on_done();
        int n;
        int k;
        push_word(DATA_W'($urandom));
        n = 0;
        while (!(m_active && m_pos == FLEN - 1) && n < 4 * FLEN) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.tx_done !== 1'b1) begin errors++; $display("FAIL pod_done got %b want 1", bus.tx_done); end
        push_word(DATA_W'($urandom));
        k = 0;
        while (bus.txd !== 1'b0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k !== 1) begin errors++; $display("FAIL pod_idle_gap got %0d want 1", k); end
        wait_idle("pod");
    endtask

    task automatic test_random();
        int done0;
        done0 = tot_done;
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 2 * CLKS)) @(negedge clk);
            push_word(DATA_W'($urandom));
        end
        wait_idle("random");
        checks++;
        if (tot_done - done0 !== 20) begin errors++; $display("FAIL random_done_count got %0d want 20", tot_done - done0); end
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_hold_valid();
        test_reset_mid();
        test_push_on_done();
        test_random();
        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
